// File: rtl/apb_pcie_pkg.sv
// Shared PCIe/APB definitions: DMA arbiter state encoding, register image and reset value.
package apb_pcie_pkg;

    typedef enum logic [1:0] {
        PDA_IDLE  = 2'd0,
        PDA_ISSUE = 2'd1,
        PDA_WAIT  = 2'd2,
        PDA_RESP  = 2'd3
    } pcie_dma_arbiter_state;

    // Fields are sized for the largest legal configuration (8 requesters, 32-bit length/watchdog)
    typedef struct packed {
        pcie_dma_arbiter_state state;
        logic [2:0]            rr;
        logic [2:0]            owner;
        logic                  write;
        logic [63:0]           addr;
        logic [31:0]           bytes;
        logic [31:0]           wdog;
        logic                  err;
        logic                  dma_valid;
        logic [7:0]            req_ready;
        logic [7:0]            resp_valid;
    } pcie_dma_arbiter_registers;

    localparam pcie_dma_arbiter_registers pcie_dma_arbiter_r_reset = '{
        state:      PDA_IDLE,
        rr:         3'd0,
        owner:      3'd0,
        write:      1'b0,
        addr:       64'd0,
        bytes:      32'd0,
        wdog:       32'd0,
        err:        1'b0,
        dma_valid:  1'b0,
        req_ready:  8'd0,
        resp_valid: 8'd0
    };

endpackage

// File: rtl/pcie_rr_pick.sv
// Combinational round-robin picker: first set bit of valid at or after rr, cyclically.
module pcie_rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] valid,
    input  logic [2:0]      rr,
    output logic            found,
    output logic [2:0]      idx
);

    logic [2*NREQ-1:0] dbl_s;
    logic [NREQ-1:0]   rot_s;
    logic [2:0]        off_s;
    logic [3:0]        sum_s;

    // Rotate so rr lands at bit 0, then take the lowest set bit as the offset
    always_comb begin
        dbl_s = {valid, valid} >> rr;
        rot_s = dbl_s[NREQ-1:0];
        off_s = 3'd0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            off_s = rot_s[i] ? 3'(i) : off_s;
        end
        sum_s = {1'b0, rr} + {1'b0, off_s};
        idx   = (sum_s >= 4'(NREQ)) ? 3'(sum_s - 4'(NREQ)) : sum_s[2:0];
        found = |valid;
    end

endmodule

// File: rtl/pcie_dma_arbiter.sv
// Round-robin owner of the single PCIe DMA engine: grant, issue, wait (watchdog/link guarded), respond.
module pcie_dma_arbiter
    import apb_pcie_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TMO_W   = 16,
    parameter int BYTES_W = 12
) (
    input  logic                    i_clk,
    input  logic                    i_nrst,
    input  logic                    i_lnk_up,
    input  logic [NREQ-1:0]         i_req_valid,
    input  logic [NREQ-1:0]         i_req_write,
    input  logic [NREQ*64-1:0]      i_req_addr,
    input  logic [NREQ*BYTES_W-1:0] i_req_bytes,
    output logic [NREQ-1:0]         o_req_ready,
    output logic [NREQ-1:0]         o_resp_valid,
    output logic [NREQ-1:0]         o_resp_err,
    output logic                    o_dma_valid,
    input  logic                    i_dma_ready,
    output logic                    o_dma_write,
    output logic [63:0]             o_dma_addr,
    output logic [BYTES_W-1:0]      o_dma_bytes,
    input  logic                    i_dma_done,
    input  logic                    i_dma_err,
    output logic                    o_dma_busy,
    output logic [2:0]              o_owner
);

    pcie_dma_arbiter_registers r, rin;

    logic               pick_found_s;
    logic [2:0]         pick_idx_s;
    logic               sel_write_s;
    logic [63:0]        sel_addr_s;
    logic [BYTES_W-1:0] sel_bytes_s;
    logic [TMO_W-1:0]   wdog_inc_s;
    logic               unused_s;

    pcie_rr_pick #(.NREQ(NREQ)) u_pick (
        .valid (i_req_valid),
        .rr    (r.rr),
        .found (pick_found_s),
        .idx   (pick_idx_s)
    );

    // Mux the picked requester's command fields
    always_comb begin
        sel_write_s = 1'b0;
        sel_addr_s  = 64'd0;
        sel_bytes_s = {BYTES_W{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            sel_write_s = (pick_idx_s == 3'(k)) ? i_req_write[k]                   : sel_write_s;
            sel_addr_s  = (pick_idx_s == 3'(k)) ? i_req_addr[64*k +: 64]           : sel_addr_s;
            sel_bytes_s = (pick_idx_s == 3'(k)) ? i_req_bytes[BYTES_W*k +: BYTES_W] : sel_bytes_s;
        end
    end

    assign wdog_inc_s = r.wdog[TMO_W-1:0] + {{(TMO_W-1){1'b0}}, 1'b1};

    // Next-state and next-output computation
    always_comb begin : comb_proc
        rin            = r;
        rin.req_ready  = 8'd0;
        rin.resp_valid = 8'd0;
        case (r.state)
            PDA_IDLE: begin
                if (i_lnk_up && pick_found_s) begin
                    rin.state                 = PDA_ISSUE;
                    rin.owner                 = pick_idx_s;
                    rin.rr                    = (pick_idx_s == 3'(NREQ - 1)) ? 3'd0 : pick_idx_s + 3'd1;
                    rin.write                 = sel_write_s;
                    rin.addr                  = sel_addr_s;
                    rin.bytes                 = 32'(sel_bytes_s);
                    rin.err                   = 1'b0;
                    rin.dma_valid             = 1'b1;
                    rin.req_ready[pick_idx_s] = 1'b1;
                end else begin
                    rin.state = PDA_IDLE;
                end
            end
            PDA_ISSUE: begin
                // Link loss beats a same-cycle engine accept
                if (!i_lnk_up) begin
                    rin.state              = PDA_RESP;
                    rin.dma_valid          = 1'b0;
                    rin.err                = 1'b1;
                    rin.resp_valid[r.owner] = 1'b1;
                end else if (i_dma_ready) begin
                    rin.state     = PDA_WAIT;
                    rin.dma_valid = 1'b0;
                    rin.wdog      = 32'd0;
                end else begin
                    rin.state = PDA_ISSUE;
                end
            end
            PDA_WAIT: begin
                if (i_dma_done) begin
                    rin.state               = PDA_RESP;
                    rin.err                 = i_dma_err;
                    rin.resp_valid[r.owner] = 1'b1;
                end else if (!i_lnk_up || (wdog_inc_s == {TMO_W{1'b1}})) begin
                    rin.state               = PDA_RESP;
                    rin.err                 = 1'b1;
                    rin.resp_valid[r.owner] = 1'b1;
                end else begin
                    rin.wdog = 32'(wdog_inc_s);
                end
            end
            PDA_RESP: begin
                rin.state = PDA_IDLE;
            end
            default: begin
                rin = pcie_dma_arbiter_r_reset;
            end
        endcase
    end

    // Register image with asynchronous active-low reset
    always_ff @(posedge i_clk or negedge i_nrst) begin : rg_proc
        if (!i_nrst) begin
            r <= pcie_dma_arbiter_r_reset;
        end else begin
            r <= rin;
        end
    end

    assign o_req_ready  = r.req_ready[NREQ-1:0];
    assign o_resp_valid = r.resp_valid[NREQ-1:0];
    assign o_resp_err   = r.err ? r.resp_valid[NREQ-1:0] : {NREQ{1'b0}};
    assign o_dma_valid  = r.dma_valid;
    assign o_dma_write  = r.write;
    assign o_dma_addr   = r.addr;
    assign o_dma_bytes  = r.bytes[BYTES_W-1:0];
    assign o_dma_busy   = (r.state != PDA_IDLE);
    assign o_owner      = r.owner;

    // High field bits exist only for wider configurations
    assign unused_s = ^{r.wdog, r.bytes, r.req_ready, r.resp_valid};

endmodule

// File: tb/tb_pcie_dma_arbiter.sv
// Directed scoreboard bench for pcie_dma_arbiter (NREQ=4, TMO_W=4, BYTES_W=12).
module tb_pcie_dma_arbiter;

    localparam int NREQ    = 4;
    localparam int TMO_W   = 4;
    localparam int BYTES_W = 12;

    logic                    i_clk = 1'b0;
    logic                    i_nrst;
    logic                    i_lnk_up;
    logic [NREQ-1:0]         i_req_valid;
    logic [NREQ-1:0]         i_req_write;
    logic [NREQ*64-1:0]      i_req_addr;
    logic [NREQ*BYTES_W-1:0] i_req_bytes;
    logic [NREQ-1:0]         o_req_ready;
    logic [NREQ-1:0]         o_resp_valid;
    logic [NREQ-1:0]         o_resp_err;
    logic                    o_dma_valid;
    logic                    i_dma_ready;
    logic                    o_dma_write;
    logic [63:0]             o_dma_addr;
    logic [BYTES_W-1:0]      o_dma_bytes;
    logic                    i_dma_done;
    logic                    i_dma_err;
    logic                    o_dma_busy;
    logic [2:0]              o_owner;

    typedef struct {
        int          idx;
        logic [63:0] addr;
        logic [11:0] bytes;
        logic        wr;
    } grant_t;

    typedef struct {
        int   idx;
        logic err;
    } resp_t;

    grant_t      gq[$];
    resp_t       rq[$];
    logic [63:0] addr_a[NREQ];
    logic [11:0] bytes_a[NREQ];
    logic        wr_a[NREQ];

    int checks     = 0;
    int failures   = 0;
    int grant_cnt  = 0;
    int resp_cnt   = 0;
    int exp_grants = 0;
    int exp_resps  = 0;

    pcie_dma_arbiter #(.NREQ(NREQ), .TMO_W(TMO_W), .BYTES_W(BYTES_W)) dut (
        .i_clk        (i_clk),
        .i_nrst       (i_nrst),
        .i_lnk_up     (i_lnk_up),
        .i_req_valid  (i_req_valid),
        .i_req_write  (i_req_write),
        .i_req_addr   (i_req_addr),
        .i_req_bytes  (i_req_bytes),
        .o_req_ready  (o_req_ready),
        .o_resp_valid (o_resp_valid),
        .o_resp_err   (o_resp_err),
        .o_dma_valid  (o_dma_valid),
        .i_dma_ready  (i_dma_ready),
        .o_dma_write  (o_dma_write),
        .o_dma_addr   (o_dma_addr),
        .o_dma_bytes  (o_dma_bytes),
        .i_dma_done   (i_dma_done),
        .i_dma_err    (i_dma_err),
        .o_dma_busy   (o_dma_busy),
        .o_owner      (o_owner)
    );

    always #5 i_clk = ~i_clk;

    // Count every accept and response pulse the DUT produces
    always @(negedge i_clk) begin
        if (o_req_ready != 4'd0) grant_cnt++;
        if (o_resp_valid != 4'd0) resp_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int k, input logic wr, input logic [63:0] a, input logic [11:0] b);
        wr_a[k]                    = wr;
        addr_a[k]                  = a;
        bytes_a[k]                 = b;
        i_req_write[k]             = wr;
        i_req_addr[64*k +: 64]     = a;
        i_req_bytes[12*k +: 12]    = b;
    endtask

    task automatic push_grant(input int k);
        grant_t g;
        g.idx   = k;
        g.addr  = addr_a[k];
        g.bytes = bytes_a[k];
        g.wr    = wr_a[k];
        gq.push_back(g);
        exp_grants++;
    endtask

    task automatic push_resp(input int k, input logic e);
        resp_t x;
        x.idx = k;
        x.err = e;
        rq.push_back(x);
        exp_resps++;
    endtask

    task automatic wait_grant(input int bound);
        grant_t     g;
        logic       seen;
        logic [3:0] oh;
        seen = 1'b0;
        for (int n = 0; n < bound && !seen; n++) begin
            @(negedge i_clk);
            seen = (o_req_ready != 4'd0);
        end
        chk("grant_seen", {63'd0, seen}, 64'd1);
        chk("grant_queue_nonempty", {63'd0, gq.size() != 0}, 64'd1);
        if (gq.size() != 0) begin
            g = gq.pop_front();
        end else begin
            g.idx = 0; g.addr = 64'd0; g.bytes = 12'd0; g.wr = 1'b0;
        end
        if (seen) begin
            oh = 4'b0001 << g.idx;
            chk("req_ready", {60'd0, o_req_ready}, {60'd0, oh});
            chk("owner", {61'd0, o_owner}, 64'(g.idx));
            chk("dma_valid", {63'd0, o_dma_valid}, 64'd1);
            chk("dma_addr", o_dma_addr, g.addr);
            chk("dma_bytes", {52'd0, o_dma_bytes}, {52'd0, g.bytes});
            chk("dma_write", {63'd0, o_dma_write}, {63'd0, g.wr});
            chk("busy_issue", {63'd0, o_dma_busy}, 64'd1);
            i_req_valid[g.idx] = 1'b0;
        end
    endtask

    task automatic accept_cmd();
        i_dma_ready = 1'b1;
        @(negedge i_clk);
        i_dma_ready = 1'b0;
        chk("req_ready_pulse", {60'd0, o_req_ready}, 64'd0);
        chk("dma_valid_drop", {63'd0, o_dma_valid}, 64'd0);
        chk("busy_wait", {63'd0, o_dma_busy}, 64'd1);
    endtask

    task automatic expect_resp();
        resp_t      x;
        logic [3:0] oh;
        @(negedge i_clk);
        i_dma_done  = 1'b0;
        i_dma_err   = 1'b0;
        i_dma_ready = 1'b0;
        chk("resp_queue_nonempty", {63'd0, rq.size() != 0}, 64'd1);
        if (rq.size() != 0) begin
            x = rq.pop_front();
        end else begin
            x.idx = 0; x.err = 1'b0;
        end
        oh = 4'b0001 << x.idx;
        chk("resp_valid", {60'd0, o_resp_valid}, {60'd0, oh});
        chk("resp_err", {60'd0, o_resp_err}, x.err ? {60'd0, oh} : 64'd0);
        chk("busy_resp", {63'd0, o_dma_busy}, 64'd1);
        chk("dma_valid_resp", {63'd0, o_dma_valid}, 64'd0);
        @(negedge i_clk);
        chk("resp_pulse", {60'd0, o_resp_valid}, 64'd0);
        chk("busy_idle", {63'd0, o_dma_busy}, 64'd0);
    endtask

    task automatic finish_xfer(input int k, input logic e);
        push_resp(k, e);
        i_dma_done = 1'b1;
        i_dma_err  = e;
        expect_resp();
    endtask

    initial begin
        int   order[5];
        logic early;
        order = '{0, 1, 2, 3, 0};
        i_nrst      = 1'b1;
        i_lnk_up    = 1'b0;
        i_req_valid = 4'd0;
        i_req_write = 4'd0;
        i_req_addr  = '0;
        i_req_bytes = '0;
        i_dma_ready = 1'b0;
        i_dma_done  = 1'b0;
        i_dma_err   = 1'b0;
        for (int k = 0; k < NREQ; k++) load(k, 1'b0, 64'd0, 12'd0);
        #1 i_nrst = 1'b0;
        #1;
        chk("rst_req_ready", {60'd0, o_req_ready}, 64'd0);
        chk("rst_resp_valid", {60'd0, o_resp_valid}, 64'd0);
        chk("rst_dma_valid", {63'd0, o_dma_valid}, 64'd0);
        chk("rst_dma_addr", o_dma_addr, 64'd0);
        chk("rst_dma_bytes", {52'd0, o_dma_bytes}, 64'd0);
        chk("rst_owner", {61'd0, o_owner}, 64'd0);
        chk("rst_busy", {63'd0, o_dma_busy}, 64'd0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_nrst   = 1'b1;
        i_lnk_up = 1'b1;

        // Single request from requester 2
        load(2, 1'b0, 64'h1000, 12'd64);
        i_req_valid = 4'b0100;
        push_grant(2);
        wait_grant(1);
        accept_cmd();
        repeat (2) @(negedge i_clk);
        finish_xfer(2, 1'b0);

        // Fresh pointer, everyone requesting continuously
        i_nrst = 1'b0;
        @(negedge i_clk);
        i_nrst = 1'b1;
        load(0, 1'b1, 64'hFFFF_0000_DEAD_BEE0, 12'd0);
        load(1, 1'b0, 64'h0000_0000_0000_2000, 12'hFFF);
        load(2, 1'b1, 64'h0000_0001_0000_3000, 12'd128);
        load(3, 1'b0, 64'h8000_0000_0000_4000, 12'd1);
        i_req_valid = 4'b1111;
        for (int n = 0; n < 5; n++) push_grant(order[n]);
        for (int n = 0; n < 5; n++) begin
            wait_grant(1);
            i_req_valid = (n < 4) ? 4'b1111 : 4'b0000;
            accept_cmd();
            finish_xfer(order[n], 1'b0);
        end

        // Link drop while waiting for completion, then no grants while down
        load(1, 1'b1, 64'h0000_0001_2345_6780, 12'd256);
        i_req_valid = 4'b0010;
        push_grant(1);
        wait_grant(1);
        accept_cmd();
        @(negedge i_clk);
        push_resp(1, 1'b1);
        i_lnk_up = 1'b0;
        expect_resp();
        i_req_valid = 4'b0001;
        for (int n = 0; n < 5; n++) begin
            @(negedge i_clk);
            chk("no_grant_lnk_down", {60'd0, o_req_ready}, 64'd0);
        end
        i_lnk_up = 1'b1;
        push_grant(0);
        wait_grant(1);
        // Link drop in ISSUE with a simultaneous engine accept
        i_lnk_up    = 1'b0;
        i_dma_ready = 1'b1;
        push_resp(0, 1'b1);
        expect_resp();
        i_lnk_up = 1'b1;

        // Silent engine: watchdog fires after 15 WAIT cycles
        i_req_valid = 4'b1000;
        push_grant(3);
        wait_grant(1);
        accept_cmd();
        early = 1'b0;
        repeat (14) begin
            @(negedge i_clk);
            if (o_resp_valid != 4'd0) early = 1'b1;
        end
        chk("tmo_early", {63'd0, early}, 64'd0);
        push_resp(3, 1'b1);
        expect_resp();

        // Done and link fall together: done wins
        i_req_valid = 4'b0001;
        push_grant(0);
        wait_grant(1);
        accept_cmd();
        @(negedge i_clk);
        i_lnk_up = 1'b0;
        finish_xfer(0, 1'b0);
        i_lnk_up = 1'b1;
        // Stray done while idle
        i_dma_done = 1'b1;
        i_dma_err  = 1'b1;
        @(negedge i_clk);
        i_dma_done = 1'b0;
        i_dma_err  = 1'b0;
        for (int n = 0; n < 3; n++) begin
            chk("stray_done_resp", {60'd0, o_resp_valid}, 64'd0);
            chk("stray_done_busy", {63'd0, o_dma_busy}, 64'd0);
            @(negedge i_clk);
        end

        // Asynchronous reset in WAIT
        load(2, 1'b1, 64'h0000_0000_CAFE_0000, 12'd32);
        i_req_valid = 4'b0100;
        push_grant(2);
        wait_grant(1);
        accept_cmd();
        @(negedge i_clk);
        #3 i_nrst = 1'b0;
        #1;
        chk("async_rst_busy", {63'd0, o_dma_busy}, 64'd0);
        chk("async_rst_owner", {61'd0, o_owner}, 64'd0);
        chk("async_rst_addr", o_dma_addr, 64'd0);
        chk("async_rst_bytes", {52'd0, o_dma_bytes}, 64'd0);
        chk("async_rst_write", {63'd0, o_dma_write}, 64'd0);
        chk("async_rst_resp", {60'd0, o_resp_valid}, 64'd0);
        @(negedge i_clk);
        i_nrst      = 1'b1;
        i_req_valid = 4'b1111;
        push_grant(0);
        wait_grant(1);
        i_req_valid = 4'b0000;
        accept_cmd();
        finish_xfer(0, 1'b0);

        @(negedge i_clk);
        chk("grant_total", 64'(grant_cnt), 64'(exp_grants));
        chk("resp_total", 64'(resp_cnt), 64'(exp_resps));
        chk("grant_queue_empty", 64'(gq.size()), 64'd0);
        chk("resp_queue_empty", 64'(rq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
